// File: rtl/ssp_fifo_pkg.sv
// Shared SSP FIFO constants and width helpers; used by both receive and transmit FIFOs.
// No logic of its own, so no latency or backpressure applies.
package ssp_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full FIFO (level == depth) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [lvl_w(DEF_DEPTH)-1:0] level_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x WIDTH register array: one write port, one registered read port.
// Read data appears one cycle after rd_en; no backpressure, the caller gates both ports.
module rx_fifo_mem
  import ssp_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ptr_w(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_dat,
  input  logic                    rd_en,
  input  logic                    rd_clr,
  input  logic [ptr_w(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]        rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Only the output register is reset; the array contents are don't-care.
  always_ff @(posedge clk) begin
    if (rst || rd_clr) rd_dat <= '0;
    else if (rd_en)    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_fifo.sv
// SSP receive FIFO: serial side pushes on RxValid, host pops via PSEL_RX/PWRITE_RX; read latency 1.
// Pushes into a full FIFO are dropped and flagged as overrun; define RX_TIMEOUT_EN for the SSPRTINTR idle timeout.
module rx_fifo
  import ssp_fifo_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int THRESH      = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                    PCLK_RX,
  input  logic                    CLEAR_RX,
  input  logic                    PSEL_RX,
  input  logic                    PWRITE_RX,
  output logic [WIDTH-1:0]        PRDATA_RX,
  input  logic [WIDTH-1:0]        RxData,
  input  logic                    RxValid,
  output logic                    SSPRXINTR,
  output logic                    SSPRORINTR,
  output logic [lvl_w(DEPTH)-1:0] RxLevel,
  output logic                    RxEmpty,
`ifdef RX_TIMEOUT_EN
  output logic                    SSPRTINTR,
`endif
  output logic                    RxFull
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          ovr_flag;
  logic          rd_req, pop, push, overrun;

  assign rd_req  = PSEL_RX && !PWRITE_RX;
  assign pop     = rd_req && !RxEmpty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
  assign push    = RxValid && (!RxFull || pop);
  assign overrun = RxValid && RxFull && !pop;

  always_ff @(posedge PCLK_RX) begin
    if (CLEAR_RX) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovr_flag <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
      if (pop)          ovr_flag <= 1'b0;
      else if (overrun) ovr_flag <= 1'b1;
    end
  end

  assign RxLevel    = level;
  assign RxEmpty    = (level == '0);
  assign RxFull     = (level == LW'(DEPTH));
  assign SSPRXINTR  = (level >= LW'(THRESH));
  assign SSPRORINTR = ovr_flag;

  rx_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (PCLK_RX),
    .rst     (CLEAR_RX),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_dat  (RxData),
    .rd_en   (pop),
    .rd_clr  (rd_req && RxEmpty),
    .rd_addr (rd_ptr),
    .rd_dat  (PRDATA_RX)
  );

`ifdef RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] idle_cnt;

  always_ff @(posedge PCLK_RX) begin
    if (CLEAR_RX || push || pop || RxEmpty)    idle_cnt <= '0;
    else if (idle_cnt != CW'(TIMEOUT_CYC))     idle_cnt <= idle_cnt + CW'(1);
  end

  assign SSPRTINTR = (idle_cnt == CW'(TIMEOUT_CYC)) && !RxEmpty;
`endif

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive-side counterpart of the transmit FIFO in the SSP path.
- The serial receive logic pushes deserialized bytes in through a valid strobe.
- The host pops them over the same select/write-strobe bus style used by the transmit FIFO.
- Provides level status, a threshold interrupt, and a sticky overrun flag.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, number of entries; power of two, at least 2.
- THRESH, 4, occupancy at or above which SSPRXINTR asserts; range 1..DEPTH.
- TIMEOUT_CYC, 32, idle cycles before the timeout interrupt fires (RX_TIMEOUT_EN only).

Ports:
- PCLK_RX  in  1  clock; all logic on the rising edge.
- CLEAR_RX  in  1  reset, synchronous, active-high.
- PSEL_RX  in  1  bus select for this block.
- PWRITE_RX  in  1  1 = write (ignored), 0 = read/pop.
- PRDATA_RX  out  WIDTH  popped data, registered.
- RxData  in  WIDTH  byte from the serial receiver.
- RxValid  in  1  one-cycle push strobe qualifying RxData.
- SSPRXINTR  out  1  level interrupt, high while level >= THRESH.
- SSPRORINTR  out  1  sticky receive-overrun flag.
- RxLevel  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- RxEmpty  out  1  level == 0.
- RxFull  out  1  level == DEPTH.

Behaviour:
- Reset (CLEAR_RX high at an edge, overrides everything):
  - Pointers and level cleared; PRDATA_RX = 0.
  - SSPRXINTR = 0, SSPRORINTR = 0, RxEmpty = 1, RxFull = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries and any same-cycle push or pop.
- Push = RxValid && !RxFull.
  - Writes RxData at the write pointer.
  - Write pointer wraps modulo DEPTH; level increments.
- Pop = PSEL_RX && !PWRITE_RX && !RxEmpty.
  - PRDATA_RX loads the entry at the read pointer on the same edge, so data is visible the cycle after the request (latency 1).
  - Read pointer wraps; level decrements.
- Pop request while empty: PRDATA_RX loads 0, pointers and level unchanged.
- PSEL_RX && PWRITE_RX: no effect; PRDATA_RX holds its value.
- PSEL_RX low: PRDATA_RX holds.
- Simultaneous push and pop:
  - Not full and not empty: both performed, level unchanged.
  - When full: the pop frees a slot, so the push is accepted, no overrun, level stays DEPTH.
  - When empty: the push is accepted, the pop returns 0. There is no bypass.
- Overrun: RxValid while RxFull and no same-cycle pop.
  - Byte dropped, storage unchanged.
  - SSPRORINTR set next edge.
  - SSPRORINTR clears only on reset or on the next successful pop.
- Status outputs:
  - SSPRXINTR, RxEmpty, RxFull and RxLevel derive from the registered level only.
  - They update on the same edge as the level.
- Arithmetic:
  - Pointers are clog2(DEPTH) bits with natural wrap.
  - Level uses one extra bit and never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- When defined:
  - Adds output SSPRTINTR (1 bit) and an idle counter.
  - The counter resets to 0 on any push, any pop, reset, or while empty; otherwise it increments, saturating at TIMEOUT_CYC.
  - SSPRTINTR = 1 while the counter == TIMEOUT_CYC and the FIFO is not empty; it clears on the next push or pop.
- When undefined:
  - No port, no counter, behaviour otherwise identical.

Decomposition:
- Shared package ssp_fifo_pkg holds:
  - default WIDTH/DEPTH constants;
  - the pointer-width and level-width derivation (clog2-based);
  - a level typedef, also reused by the transmit-side FIFO.
- One sub-module, rx_fifo_mem: DEPTH x WIDTH register array, one write port, one registered read port, no reset on storage.
- Pointer, level, flag and interrupt control stay in rx_fifo.

Test Plan:
- Reset then push 0xA1,0xB2,0xC3 -> RxLevel = 3, SSPRXINTR = 0; three pops return 0xA1,0xB2,0xC3 one cycle after each request; RxEmpty = 1 afterwards.
- Push 4 bytes 0x10..0x13 -> RxFull = 1, SSPRXINTR = 1; a fifth push of 0x14 -> SSPRORINTR = 1 and the next pop returns 0x10 and clears SSPRORINTR; 0x14 never appears.
- When full, push 0x55 and pop in the same cycle -> PRDATA_RX = oldest entry, RxLevel stays 4, SSPRORINTR = 0, and 0x55 is popped last.
- Pop when empty -> PRDATA_RX = 0x00, RxLevel = 0; simultaneous push 0x7E + pop when empty -> PRDATA_RX = 0x00, next pop returns 0x7E.
- Fill 2, pop 2, repeat 6 times -> pointers wrap and data order is preserved; assert CLEAR_RX with level 3 -> next cycle level 0, flags 0, PRDATA_RX = 0.
- RX_TIMEOUT_EN: push 0x01, idle 32 cycles -> SSPRTINTR = 1; pop -> SSPRTINTR = 0 next cycle; idle with empty FIFO -> SSPRTINTR stays 0.
